dmem_arbiter: RTL and testbench

//   Shares the single-port data memory (7-bit address, 32-bit word, 1-cycle registered read) among
//   NUM_REQ requesters. Issues at most one access per cycle, using round-robin priority.
//   An optional short lock gives one requester back-to-back accesses, e.g. for read-modify-write.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/rr_priority_pick.sv | 34 +++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arb_pkg : shared types and default widths for the dmem arbiter       |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter_if : requester bus plus memory pins around the arbiter      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) ();

  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ-1:0]        ReqWrite;
  logic [NUM_REQ-1:0]        ReqLock;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqWData;
  logic [NUM_REQ-1:0]        ReqReady;
  logic [NUM_REQ-1:0]        RspValid;
  logic [DATA_W-1:0]         RspData;
  logic [ADDR_W-1:0]         MemAddress;
  logic [DATA_W-1:0]         MemWriteData;
  logic                      MemRead;
  logic                      MemWrite;
  logic [DATA_W-1:0]         MemReadData;

  // Requesters and memory together form the environment around the arbiter.
  modport master (
    output ReqValid, ReqWrite, ReqLock, ReqAddr, ReqWData, MemReadData,
    input  ReqReady, RspValid, RspData, MemAddress, MemWriteData, MemRead, MemWrite
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqLock, ReqAddr, ReqWData, MemReadData,
    output ReqReady, RspValid, RspData, MemAddress, MemWriteData, MemRead, MemWrite
  );

endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_priority_pick : first requester at or after prio, wrapping around      |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [IDX_W-1:0]   prio,
  output logic      [NUM_REQ-1:0] grant,
  output logic      [IDX_W-1:0]   idx,
  output logic                    any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(prio) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : round-robin single-port data memory arbiter with lock     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = 4
) (
  input wire logic      Clk,
  input wire logic      Rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   prio_q, prio_d;
  logic [IDX_W-1:0]   lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] rr_grant, grant;
  logic [IDX_W-1:0]   rr_idx, gnt_idx;
  logic               rr_any, gnt_any;

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req  (bus.ReqValid),
    .prio (prio_q),
    .grant(rr_grant),
    .idx  (rr_idx),
    .any  (rr_any)
  );

  // Grant is gated by Rst_n directly so nothing reaches memory during reset.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (Rst_n) begin
      if (state_q == LOCKED) begin
        if (bus.ReqValid[lock_owner_q]) begin
          grant[lock_owner_q] = 1'b1;
          gnt_idx             = lock_owner_q;
          gnt_any             = 1'b1;
        end
      end else begin
        grant   = rr_grant;
        gnt_idx = rr_idx;
        gnt_any = rr_any;
      end
    end
  end

  always_comb begin
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    if (gnt_any) begin
      bus.MemAddress   = bus.ReqAddr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      bus.MemWriteData = bus.ReqWData[int'(gnt_idx)*DATA_W +: DATA_W];
      bus.MemWrite     = bus.ReqWrite[gnt_idx];
      bus.MemRead      = !bus.ReqWrite[gnt_idx];
    end
  end

  assign bus.ReqReady = grant;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspData  = (|rsp_valid_q) ? bus.MemReadData : '0;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    rsp_valid_d  = '0;
    if (gnt_any) begin
      prio_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      if (!bus.ReqWrite[gnt_idx]) rsp_valid_d[gnt_idx] = 1'b1;
      if (state_q == ARB) begin
        if (bus.ReqLock[gnt_idx] && (LOCK_MAX > 1)) begin
          state_d      = LOCKED;
          lock_owner_d = gnt_idx;
          lock_cnt_d   = CNT_W'(1);
        end
      end else if (bus.ReqLock[gnt_idx] && (int'(lock_cnt_q) + 1 < LOCK_MAX)) begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
        // Final access of the burst still goes through; only the hold ends.
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end else if (state_q == LOCKED) begin
      state_d    = ARB;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ARB;
      prio_q       <= '0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed and randomized checks of dmem_arbiter         |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LM = 4;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  dmem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  // Single-port memory with registered read; ReadData keeps its old value when idle.
  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] rdata = 32'hA5A5_5A5A;
  always @(posedge Clk) begin
    if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemWriteData;
    if (bus.MemRead)  rdata <= mem[bus.MemAddress];
  end
  assign bus.MemReadData = rdata;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_prio, m_owner, m_burst;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] ref_mem [0:127];

  logic [N-1:0]  obs_ready, obs_rv, exp_ready, exp_rv;
  logic [DW-1:0] obs_rd, obs_md, exp_rd, exp_md;
  logic [AW-1:0] obs_ma, exp_ma;
  logic          obs_mr, obs_mw, exp_mr, exp_mw;

  task automatic model_reset();
    m_prio  = 0;
    m_owner = -1;
    m_burst = 0;
    m_rv    = '0;
    m_rd    = '0;
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (v[(m_prio + k) % N]) return (m_prio + k) % N;
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, w, l, input logic [AW-1:0] a0, a1,
                       input logic [DW-1:0] d0, d1);
    bus.ReqValid = v;
    bus.ReqWrite = w;
    bus.ReqLock  = l;
    bus.ReqAddr  = {a1, a0};
    bus.ReqWData = {d1, d0};
  endtask

  // One clock: capture last cycle's response, drive, sample grant, advance model.
  task automatic cycle(input logic [N-1:0] v, w, l, input logic [AW-1:0] a0, a1,
                       input logic [DW-1:0] d0, d1);
    int            g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    @(negedge Clk);
    obs_rv = bus.RspValid;
    obs_rd = bus.RspData;
    exp_rv = m_rv;
    exp_rd = (m_rv != '0) ? m_rd : '0;
    drive(v, w, l, a0, a1, d0, d1);
    #1;
    obs_ready = bus.ReqReady;
    obs_mr    = bus.MemRead;
    obs_mw    = bus.MemWrite;
    obs_ma    = bus.MemAddress;
    obs_md    = bus.MemWriteData;
    g         = model_pick(v);
    exp_ready = '0;
    exp_mr    = 1'b0;
    exp_mw    = 1'b0;
    exp_ma    = '0;
    exp_md    = '0;
    m_rv      = '0;
    if (g >= 0) begin
      ga           = (g == 1) ? a1 : a0;
      gd           = (g == 1) ? d1 : d0;
      exp_ready[g] = 1'b1;
      exp_mw       = w[g];
      exp_mr       = !w[g];
      exp_ma       = ga;
      exp_md       = gd;
      if (w[g]) ref_mem[ga] = gd;
      else begin
        m_rv[g] = 1'b1;
        m_rd    = ref_mem[ga];
      end
      m_prio = (g + 1) % N;
      if (m_owner < 0) begin
        if (l[g] && LM > 1) begin
          m_owner = g;
          m_burst = 1;
        end
      end else begin
        m_burst++;
        if (!l[g] || m_burst == LM) m_owner = -1;
      end
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 7'h01, 7'h02, '0, '0);
    model_reset();
    #1;
    checks++; if (bus.ReqReady !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.ReqReady); end
    checks++; if ({bus.MemRead, bus.MemWrite} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b want 00", {bus.MemRead, bus.MemWrite}); end
    @(negedge Clk);
    checks++; if (bus.RspValid !== 2'b00) begin errors++; $display("FAIL reset_rspvalid: got %b want 00", bus.RspValid); end
    checks++; if (bus.ReqReady !== 2'b00) begin errors++; $display("FAIL reset_ready_held: got %b want 00", bus.ReqReady); end
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    cycle(2'b11, 2'b00, 2'b00, 7'h01, 7'h02, '0, '0);
    checks++; if (obs_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b want 01", obs_ready); end
  endtask

  task automatic test_read_latency();
    do_reset();
    cycle(2'b01, 2'b01, 2'b00, 7'h15, 7'h00, 32'hDEADBEEF, '0);
    checks++; if ({obs_ready, obs_mw, obs_mr} !== 4'b0110) begin errors++; $display("FAIL lat_write_grant: got %b want 0110", {obs_ready, obs_mw, obs_mr}); end
    checks++; if (obs_ma !== 7'h15 || obs_md !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_write_bus: got %h/%h want 15/deadbeef", obs_ma, obs_md); end
    cycle(2'b01, 2'b00, 2'b00, 7'h15, 7'h00, '0, '0);
    checks++; if ({obs_ready, obs_mw, obs_mr} !== 4'b0101) begin errors++; $display("FAIL lat_read_grant: got %b want 0101", {obs_ready, obs_mw, obs_mr}); end
    checks++; if (obs_rv !== 2'b00) begin errors++; $display("FAIL lat_write_no_rsp: got %b want 00", obs_rv); end
    cycle('0, '0, '0, '0, '0, '0, '0);
    checks++; if (obs_rv !== 2'b01) begin errors++; $display("FAIL lat_rspvalid: got %b want 01", obs_rv); end
    checks++; if (obs_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_rspdata: got %h want deadbeef", obs_rd); end
    cycle('0, '0, '0, '0, '0, '0, '0);
    checks++; if (obs_rv !== 2'b00 || obs_rd !== '0) begin errors++; $display("FAIL lat_idle_rsp: got %b/%h want 00/0", obs_rv, obs_rd); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, 2'b00, 2'b00, 7'h01, 7'h02, '0, '0);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (obs_ready !== want) begin errors++; $display("FAIL rr_cycle%0d: got %b want %b", i, obs_ready, want); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    cycle(2'b01, 2'b01, 2'b00, 7'h10, 7'h00, 32'h1, '0);
    cycle(2'b11, 2'b00, 2'b10, 7'h10, 7'h02, '0, '0);
    checks++; if (obs_ready !== 2'b10) begin errors++; $display("FAIL lock_first: got %b want 10", obs_ready); end
    cycle(2'b11, 2'b10, 2'b00, 7'h10, 7'h02, '0, 32'h1234_5678);
    checks++; if (obs_ready !== 2'b10 || obs_mw !== 1'b1) begin errors++; $display("FAIL lock_second: got %b/%b want 10/1", obs_ready, obs_mw); end
    cycle(2'b11, 2'b00, 2'b00, 7'h10, 7'h02, '0, '0);
    checks++; if (obs_ready !== 2'b01) begin errors++; $display("FAIL lock_release: got %b want 01", obs_ready); end
  endtask

  task automatic test_forced_release();
    logic [N-1:0] want [6];
    want = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, 2'b00, 2'b01, 7'h03, 7'h04, '0, '0);
      checks++; if (obs_ready !== want[i]) begin errors++; $display("FAIL forced_cycle%0d: got %b want %b", i, obs_ready, want[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    cycle(2'b01, 2'b00, 2'b00, 7'h03, 7'h00, '0, '0);
    @(negedge Clk);
    drive(2'b10, 2'b00, 2'b00, 7'h00, 7'h04, '0, '0);
    #1;
    checks++; if (bus.ReqReady !== 2'b10) begin errors++; $display("FAIL midrd_grant: got %b want 10", bus.ReqReady); end
    Rst_n = 1'b0;
    #1;
    checks++; if ({bus.ReqReady, bus.MemRead} !== 3'b000) begin errors++; $display("FAIL midrd_forced_off: got %b want 000", {bus.ReqReady, bus.MemRead}); end
    @(negedge Clk);
    checks++; if (bus.RspValid !== 2'b00) begin errors++; $display("FAIL midrd_no_rsp: got %b want 00", bus.RspValid); end
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    model_reset();
    cycle(2'b11, 2'b00, 2'b00, 7'h05, 7'h06, '0, '0);
    checks++; if (obs_ready !== 2'b01 || obs_rv !== 2'b00) begin errors++; $display("FAIL midrd_prio: got %b/%b want 01/00", obs_ready, obs_rv); end
  endtask

  task automatic test_random();
    logic [N-1:0] v, w, l;
    do_reset();
    for (int k = 0; k < 8; k++) cycle(2'b01, 2'b01, 2'b00, AW'(k), '0, $urandom, '0);
    for (int i = 0; i < 400; i++) begin
      v = N'($urandom);
      w = N'($urandom);
      l = N'($urandom);
      cycle(v, w, l, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom, $urandom);
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", i, obs_ready, exp_ready); end
      checks++; if ({obs_mr, obs_mw} !== {exp_mr, exp_mw}) begin errors++; $display("FAIL rnd_memctl@%0d: got %b want %b", i, {obs_mr, obs_mw}, {exp_mr, exp_mw}); end
      checks++; if (obs_ma !== exp_ma || obs_md !== exp_md) begin errors++; $display("FAIL rnd_membus@%0d: got %h/%h want %h/%h", i, obs_ma, obs_md, exp_ma, exp_md); end
      checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL rnd_rspvalid@%0d: got %b want %b", i, obs_rv, exp_rv); end
      checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_rspdata@%0d: got %h want %h", i, obs_rd, exp_rd); end
    end
  endtask

  initial begin
    drive('0, '0, '0, '0, '0, '0, '0);
    model_reset();
    test_reset();
    test_read_latency();
    test_round_robin();
    test_lock();
    test_forced_release();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
